// File: rtl/time_param_timer.sv
// time_param_timer: reprogrammable interval table with an integrated countdown
// that times the selected interval against an external one-second tick.
module time_param_timer #(
    parameter int NUM_PARAMS = 4,
    parameter int VALUE_W = 4,
    parameter logic [NUM_PARAMS*VALUE_W-1:0] DEFAULTS = {4'd1, 4'd2, 4'd3, 4'd6},
    localparam int SEL_W = (NUM_PARAMS > 2) ? $clog2(NUM_PARAMS) : 1
) (
    input  logic               clk,
    input  logic               Sync_Reset,
    input  logic               Sync_Reprogram,
    input  logic [SEL_W-1:0]   Selector,
    input  logic [VALUE_W-1:0] Time_Value,
    input  logic [SEL_W-1:0]   Interval,
    input  logic               Start_Timer,
    input  logic               Tick,
    output logic [VALUE_W-1:0] Value,
    output logic [VALUE_W-1:0] Remaining,
    output logic               Busy,
    output logic               Expired,
    output logic               Prog_Err
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [VALUE_W-1:0] tbl_q [NUM_PARAMS];
    logic [VALUE_W-1:0] value_q, rem_q, rem_d, rd;
    logic exp_q, exp_d, perr_q, iv_ok, wr_ok, start_ok;
    assign iv_ok    = int'(Interval) < NUM_PARAMS;
    assign wr_ok    = Sync_Reprogram && Time_Value != '0 && int'(Selector) < NUM_PARAMS;
    assign start_ok = Start_Timer && iv_ok;
    // Reads see the table before this edge's write, so a same-edge load gets the old value.
    assign rd       = iv_ok ? tbl_q[Interval] : '0;
    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) tbl_q[i] <= DEFAULTS[i*VALUE_W +: VALUE_W];
            state_q <= IDLE;
            value_q <= '0;
            rem_q   <= '0;
            exp_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            if (wr_ok) tbl_q[Selector] <= Time_Value;
            state_q <= state_d;
            value_q <= rd;
            rem_q   <= rem_d;
            exp_q   <= exp_d;
            perr_q  <= Sync_Reprogram && !wr_ok;
        end
    end
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        exp_d   = 1'b0;
        case (state_q)
            IDLE: if (start_ok) begin
                state_d = RUN;
                rem_d   = rd;
            end
            RUN: if (start_ok) begin
                rem_d = rd;
            end else if (Tick) begin
                rem_d   = (rem_q > VALUE_W'(1)) ? rem_q - VALUE_W'(1) : '0;
                state_d = (rem_q > VALUE_W'(1)) ? RUN : IDLE;
                exp_d   = rem_q <= VALUE_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        Busy      = state_q == RUN;
        Value     = value_q;
        Remaining = rem_q;
        Expired   = exp_q;
        Prog_Err  = perr_q;
    end
endmodule

// File: tb/tb_time_param_timer.sv
// tb_time_param_timer: scoreboard bench; a behavioural model predicts every
// cycle's outputs and a negedge monitor compares them, plus directed spot checks.
module tb_time_param_timer;
    localparam int N = 4;
    localparam int W = 4;
    localparam logic [N*W-1:0] DEF = {4'd1, 4'd2, 4'd3, 4'd6};
    logic clk = 1'b0;
    logic Sync_Reset, Sync_Reprogram, Start_Timer, Tick;
    logic [1:0] Selector, Interval;
    logic [W-1:0] Time_Value, Value, Remaining;
    logic Busy, Expired, Prog_Err;
    typedef struct {
        int val;
        int rem;
        int busy;
        int exp;
        int perr;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int mtbl[N];
    int mval, mrem, mbusy, mexp, mperr;
    int dflt[N];
    logic [N*W-1:0] defv = DEF;

    time_param_timer dut (
        .clk(clk), .Sync_Reset(Sync_Reset), .Sync_Reprogram(Sync_Reprogram),
        .Selector(Selector), .Time_Value(Time_Value), .Interval(Interval),
        .Start_Timer(Start_Timer), .Tick(Tick), .Value(Value), .Remaining(Remaining),
        .Busy(Busy), .Expired(Expired), .Prog_Err(Prog_Err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Model: table of durations, a countdown integer and a running flag.
    always @(posedge clk) begin
        if (Sync_Reset) begin
            for (int i = 0; i < N; i++) mtbl[i] = int'(defv[i*W +: W]);
            mval = 0; mrem = 0; mbusy = 0; mexp = 0; mperr = 0;
        end else begin
            mexp = 0;
            mperr = 0;
            mval = mtbl[Interval];
            if (Start_Timer) begin
                mrem = mtbl[Interval];
                mbusy = 1;
            end else if (mbusy != 0 && Tick) begin
                mrem = mrem - 1;
                if (mrem == 0) begin
                    mbusy = 0;
                    mexp = 1;
                end
            end
            if (Sync_Reprogram) begin
                if (Time_Value != 0) mtbl[Selector] = int'(Time_Value);
                else mperr = 1;
            end
        end
        q.push_back('{mval, mrem, mbusy, mexp, mperr});
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_value", int'(Value), e.val);
            chk("sb_remaining", int'(Remaining), e.rem);
            chk("sb_busy", int'(Busy), e.busy);
            chk("sb_expired", int'(Expired), e.exp);
            chk("sb_prog_err", int'(Prog_Err), e.perr);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_once();
        Tick = 1'b1;
        cyc(1);
        Tick = 1'b0;
    endtask

    task automatic check_table(input string nm);
        for (int i = 0; i < N; i++) begin
            Interval = 2'(i);
            cyc(1);
            chk(nm, int'(Value), dflt[i]);
        end
    endtask

    initial begin
        dflt = '{6, 3, 2, 1};
        Sync_Reset = 1'b1; Sync_Reprogram = 1'b0; Start_Timer = 1'b0; Tick = 1'b0;
        Selector = '0; Interval = '0; Time_Value = '0;
        cyc(3);
        chk("reset_value", int'(Value), 0);
        chk("reset_busy", int'(Busy), 0);
        Sync_Reset = 1'b0;
        check_table("default_value");
        chk("idle_busy", int'(Busy), 0);
        // Level-held write to entry 1
        Interval = 2'd1; Selector = 2'd1; Time_Value = 4'd5; Sync_Reprogram = 1'b1;
        cyc(1);
        chk("write_lat1", int'(Value), 3);
        cyc(1);
        chk("write_lat2", int'(Value), 5);
        cyc(3);
        Sync_Reprogram = 1'b0;
        dflt[1] = 5;
        check_table("after_write");
        // Rejected zero writes
        Selector = 2'd2; Time_Value = 4'd0; Sync_Reprogram = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("prog_err_pulse", int'(Prog_Err), 1);
        end
        Selector = 2'd3;
        cyc(2);
        chk("prog_err_sel3", int'(Prog_Err), 1);
        Sync_Reprogram = 1'b0;
        cyc(1);
        chk("prog_err_clear", int'(Prog_Err), 0);
        check_table("after_reject");
        // Entry 2 countdown to expiry
        Interval = 2'd2; Start_Timer = 1'b1;
        cyc(1);
        Start_Timer = 1'b0;
        chk("start_rem", int'(Remaining), 2);
        chk("start_busy", int'(Busy), 1);
        cyc(9);
        tick_once();
        chk("tick1_rem", int'(Remaining), 1);
        cyc(9);
        tick_once();
        chk("expire_rem", int'(Remaining), 0);
        chk("expire_pulse", int'(Expired), 1);
        chk("expire_busy", int'(Busy), 0);
        cyc(1);
        chk("expire_one_cycle", int'(Expired), 0);
        tick_once();
        tick_once();
        chk("idle_tick_rem", int'(Remaining), 0);
        // Capture at load, then retrigger with the new value
        Interval = 2'd0; Start_Timer = 1'b1;
        cyc(1);
        Start_Timer = 1'b0;
        chk("e0_start", int'(Remaining), 6);
        tick_once();
        tick_once();
        chk("e0_two_ticks", int'(Remaining), 4);
        Selector = 2'd0; Time_Value = 4'd9; Sync_Reprogram = 1'b1;
        cyc(1);
        Sync_Reprogram = 1'b0;
        chk("e0_captured", int'(Remaining), 4);
        tick_once();
        tick_once();
        chk("e0_before_retrig", int'(Remaining), 2);
        Start_Timer = 1'b1; Tick = 1'b1;
        cyc(1);
        Start_Timer = 1'b0; Tick = 1'b0;
        chk("retrigger_rem", int'(Remaining), 9);
        chk("retrigger_no_exp", int'(Expired), 0);
        repeat (6) tick_once();
        chk("pre_reset_rem", int'(Remaining), 3);
        Sync_Reset = 1'b1;
        cyc(1);
        Sync_Reset = 1'b0;
        chk("mid_reset_rem", int'(Remaining), 0);
        chk("mid_reset_busy", int'(Busy), 0);
        chk("mid_reset_exp", int'(Expired), 0);
        dflt = '{6, 3, 2, 1};
        check_table("table_restored");
        // Write and start on the same entry and edge: old value loads
        Interval = 2'd3; Selector = 2'd3; Time_Value = 4'd12;
        Start_Timer = 1'b1; Sync_Reprogram = 1'b1;
        cyc(1);
        Start_Timer = 1'b0; Sync_Reprogram = 1'b0;
        chk("same_edge_old", int'(Remaining), 1);
        // Random traffic, checked by the scoreboard
        for (int i = 0; i < 3000; i++) begin
            Sync_Reset = $urandom_range(0, 199) == 0;
            Sync_Reprogram = $urandom_range(0, 7) == 0;
            Selector = 2'($urandom_range(0, 3));
            Time_Value = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            Interval = 2'($urandom_range(0, 3));
            Start_Timer = $urandom_range(0, 24) == 0;
            Tick = $urandom_range(0, 2) == 0;
            cyc(1);
        end
        Sync_Reset = 1'b0; Sync_Reprogram = 1'b0; Start_Timer = 1'b0; Tick = 1'b0;
        cyc(2);
        #1;
        chk("sb_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
